// File: rtl/cmp_minmax_ctrl.sv
// Streaming min/max search engine sharing one 4-bit comparator between the max and min checks.
// Optional macro CMP_TIE_LAST_EN: on equal samples report the latest index instead of the earliest.

module comparator (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       eg,
  output logic       ut
);
  assign gt = (a > b);
  assign eg = (a == b);
  assign ut = (a < b);
endmodule

// state   | meaning
// IDLE    | waiting for the first sample of a frame
// ACCEPT  | waiting for the next sample
// CMP_MAX | comparator checks hold against running max
// CMP_MIN | comparator checks hold against running min, decides frame end
// DONE    | result presented until out_ready
module cmp_minmax_ctrl #(
  parameter int MAX_CNT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_max,
  output logic [3:0] out_min,
  output logic [3:0] out_max_idx,
  output logic [3:0] out_min_idx,
  output logic [3:0] out_count,
  output logic       out_trunc
);

  localparam logic [3:0] MAX_C = 4'(MAX_CNT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCEPT  = 3'd1,
    S_CMP_MAX = 3'd2,
    S_CMP_MIN = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] hold;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic       last_f;

  logic [3:0] cmp_a;
  logic [3:0] cmp_b;
  logic       cmp_gt;
  logic       cmp_eg;
  logic       cmp_ut;

  // The single comparator always sees hold; its reference follows the compare phase.
  assign cmp_a = hold;
  assign cmp_b = (state == S_CMP_MIN) ? out_min : out_max;

  comparator u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (cmp_gt),
    .eg (cmp_eg),
    .ut (cmp_ut)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      hold        <= 4'd0;
      idx         <= 4'd0;
      cnt         <= 4'd0;
      last_f      <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_max     <= 4'd0;
      out_min     <= 4'd0;
      out_max_idx <= 4'd0;
      out_min_idx <= 4'd0;
      out_count   <= 4'd0;
      out_trunc   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            out_max     <= in_data;
            out_min     <= in_data;
            out_max_idx <= 4'd0;
            out_min_idx <= 4'd0;
            out_count   <= 4'd1;
            out_trunc   <= 1'b0;
            cnt         <= 4'd1;
            if (in_last) begin
              state     <= S_DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= S_ACCEPT;
            end
          end
        end

        S_ACCEPT: begin
          if (in_valid && in_ready) begin
            hold     <= in_data;
            idx      <= cnt;
            cnt      <= (cnt == MAX_C) ? cnt : cnt + 4'd1;
            last_f   <= in_last;
            in_ready <= 1'b0;
            state    <= S_CMP_MAX;
          end
        end

        S_CMP_MAX: begin
          if (cmp_gt) begin
            out_max     <= hold;
            out_max_idx <= idx;
          end
`ifdef CMP_TIE_LAST_EN
          else if (cmp_eg) begin
            out_max_idx <= idx;
          end
`endif
          out_count <= cnt;
          state     <= S_CMP_MIN;
        end

        S_CMP_MIN: begin
          if (cmp_ut) begin
            out_min     <= hold;
            out_min_idx <= idx;
          end
`ifdef CMP_TIE_LAST_EN
          else if (cmp_eg) begin
            out_min_idx <= idx;
          end
`endif
          if (last_f) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else if (cnt == MAX_C) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_trunc <= 1'b1;
          end else begin
            state    <= S_ACCEPT;
            in_ready <= 1'b1;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
